// File: rtl/pid_servo_mc.sv
// pid_servo_mc: multi-channel, sample-gated PID position controller.
// One shared datapath evaluates each channel in two cycles (ERR, OUT).
// Optional macro PID_ANTIWINDUP_EN enables conditional integration:
// the integral is frozen while the output is saturated in the direction
// the error is pushing it.
module pid_servo_mc #(
  parameter int NCH        = 2,
  parameter int POS_W      = 12,
  parameter int DUTY_W     = 18,
  parameter int KP         = 100,
  parameter int KI         = 1,
  parameter int KD         = 10,
  parameter int OUT_MIN    = 50000,
  parameter int OUT_CENTER = 75000,
  parameter int OUT_MAX    = 100000,
  parameter int INT_LIM    = 65535
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_en,
  input  logic [NCH*POS_W-1:0]    setpoint,
  input  logic [NCH*POS_W-1:0]    feedback,
  output logic [NCH*DUTY_W-1:0]   duty_out,
  output logic                    duty_valid,
  output logic                    busy,
  output logic [NCH-1:0]          sat
);

  localparam int E_W  = POS_W + 1;   // signed error
  localparam int D_W  = POS_W + 2;   // signed error difference
  localparam int I_W  = 32;          // signed integral accumulator
  localparam int A_W  = 48;          // output arithmetic width
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CH_W-1:0]          LAST_CH  = CH_W'(NCH - 1);
  localparam logic signed [A_W-1:0]    KP_S     = A_W'(KP);
  localparam logic signed [A_W-1:0]    KI_S     = A_W'(KI);
  localparam logic signed [A_W-1:0]    KD_S     = A_W'(KD);
  localparam logic signed [A_W-1:0]    CENTER_S = A_W'(OUT_CENTER);
  localparam logic signed [A_W-1:0]    MAX_S    = A_W'(OUT_MAX);
  localparam logic signed [A_W-1:0]    MIN_S    = A_W'(OUT_MIN);
  localparam logic signed [A_W-1:0]    LIM_S    = A_W'(INT_LIM);
  localparam logic [DUTY_W-1:0]        MAX_DUTY = DUTY_W'(OUT_MAX);
  localparam logic [DUTY_W-1:0]        MIN_DUTY = DUTY_W'(OUT_MIN);
  localparam logic [DUTY_W-1:0]        CTR_DUTY = DUTY_W'(OUT_CENTER);

  typedef enum logic [1:0] {IDLE, ERR, OUT, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q;
  logic [NCH*POS_W-1:0]     sp_q, fb_q;
  logic signed [E_W-1:0]    e_q;
  logic signed [D_W-1:0]    d_q;
  logic signed [I_W-1:0]    i_q;
  logic signed [E_W-1:0]    last_e_q   [NCH];
  logic signed [I_W-1:0]    integral_q [NCH];
  logic [DUTY_W-1:0]        duty_q     [NCH];
  logic [NCH-1:0]           sat_q;
  logic                     duty_valid_q;

  // Datapath intermediates
  logic [POS_W-1:0]         sp_c, fb_c;
  logic signed [E_W-1:0]    e_c;
  logic signed [D_W-1:0]    d_c;
  logic signed [A_W-1:0]    i_sum_c;
  logic signed [I_W-1:0]    i_c;
  logic signed [A_W-1:0]    u_c;
  logic                     sat_hi_c, sat_lo_c;
  logic [DUTY_W-1:0]        duty_c;
  logic signed [I_W-1:0]    int_commit_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; sample_en only matters in IDLE
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sample_en) state_d = ERR;
      ERR:  state_d = OUT;
      OUT:  state_d = (ch_q == LAST_CH) ? DONE : ERR;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Shared arithmetic: error/derivative/integral for ERR, duty for OUT
  always_comb begin
    sp_c    = sp_q[int'(ch_q)*POS_W +: POS_W];
    fb_c    = fb_q[int'(ch_q)*POS_W +: POS_W];
    e_c     = $signed({1'b0, sp_c}) - $signed({1'b0, fb_c});
    d_c     = D_W'(e_c) - D_W'(last_e_q[ch_q]);
    i_sum_c = A_W'(integral_q[ch_q]) + A_W'(e_c);
    if (i_sum_c > LIM_S)       i_c = I_W'(LIM_S);
    else if (i_sum_c < -LIM_S) i_c = I_W'(-LIM_S);
    else                       i_c = I_W'(i_sum_c);

    u_c = CENTER_S + KP_S * A_W'(e_q) + KI_S * A_W'(i_q) + KD_S * A_W'(d_q);
    sat_hi_c = (u_c > MAX_S);
    sat_lo_c = (u_c < MIN_S);
    if (sat_hi_c)      duty_c = MAX_DUTY;
    else if (sat_lo_c) duty_c = MIN_DUTY;
    else               duty_c = DUTY_W'(u_c);

`ifdef PID_ANTIWINDUP_EN
    // Freeze integration while saturated in the direction of the error
    if ((sat_hi_c && e_q > 0) || (sat_lo_c && e_q < 0)) int_commit_c = integral_q[ch_q];
    else                                                int_commit_c = i_q;
`else
    int_commit_c = i_q;
`endif
  end

  // Datapath registers: snapshot, per-step pipeline and per-channel state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q         <= '0;
      sp_q         <= '0;
      fb_q         <= '0;
      e_q          <= '0;
      d_q          <= '0;
      i_q          <= '0;
      sat_q        <= '0;
      duty_valid_q <= 1'b0;
      // NOTE: these per-channel arrays are controller state that must start
      // from zero / center, so they are reset like ordinary registers rather
      // than mapped to RAM.
      for (int c = 0; c < NCH; c++) begin
        last_e_q[c]   <= '0;
        integral_q[c] <= '0;
        duty_q[c]     <= CTR_DUTY;
      end
    end else begin
      duty_valid_q <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (sample_en) begin
            sp_q <= setpoint;
            fb_q <= feedback;
            ch_q <= '0;
          end
        end
        ERR: begin
          e_q <= e_c;
          d_q <= d_c;
          i_q <= i_c;
        end
        OUT: begin
          duty_q[ch_q]     <= duty_c;
          sat_q[ch_q]      <= sat_hi_c | sat_lo_c;
          last_e_q[ch_q]   <= e_q;
          integral_q[ch_q] <= int_commit_c;
          if (ch_q != LAST_CH) ch_q <= ch_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Pack per-channel duty words onto the output bus
  always_comb begin
    duty_out = '0;
    for (int c = 0; c < NCH; c++) duty_out[c*DUTY_W +: DUTY_W] = duty_q[c];
  end

  assign sat        = sat_q;
  assign duty_valid = duty_valid_q;

endmodule

// File: tb/tb_pid_servo_mc.sv
// Self-checking bench for pid_servo_mc (NCH=2, default parameters).
// A behavioural PID model pushes expected results into a scoreboard queue
// when a sample is launched; they are popped when duty_valid pulses.
module tb_pid_servo_mc;

  localparam int NCH     = 2;
  localparam int POS_W   = 12;
  localparam int DUTY_W  = 18;
  localparam longint KP  = 100;
  localparam longint KI  = 1;
  localparam longint KD  = 10;
  localparam longint OMIN = 50000;
  localparam longint OCTR = 75000;
  localparam longint OMAX = 100000;
  localparam longint ILIM = 65535;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sample_en;
  logic [NCH*POS_W-1:0]   setpoint, feedback;
  logic [NCH*DUTY_W-1:0]  duty_out;
  logic                   duty_valid, busy;
  logic [NCH-1:0]         sat;

  pid_servo_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .setpoint   (setpoint),
    .feedback   (feedback),
    .duty_out   (duty_out),
    .duty_valid (duty_valid),
    .busy       (busy),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d0;
    longint d1;
    longint s;
  } exp_t;

  exp_t   sb_q[$];
  int     checks   = 0;
  int     failures = 0;

  // Reference model state
  longint m_int[2];
  longint m_last[2];
  longint m_duty[2];
  longint m_sat[2];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_int[c] = 0; m_last[c] = 0; m_duty[c] = OCTR; m_sat[c] = 0;
    end
  endtask

  task automatic model_sample(input int sp0, input int fb0, input int sp1, input int fb1);
    longint sp[2], fb[2], e, d, i, u;
    bit     hi, lo;
    exp_t   ex;
    sp[0] = sp0; fb[0] = fb0; sp[1] = sp1; fb[1] = fb1;
    for (int c = 0; c < 2; c++) begin
      e = sp[c] - fb[c];
      d = e - m_last[c];
      i = m_int[c] + e;
      if (i > ILIM) i = ILIM;
      if (i < -ILIM) i = -ILIM;
      u = OCTR + KP * e + KI * i + KD * d;
      hi = (u > OMAX);
      lo = (u < OMIN);
      m_duty[c] = hi ? OMAX : (lo ? OMIN : u);
      m_sat[c]  = (hi || lo) ? 1 : 0;
`ifdef PID_ANTIWINDUP_EN
      if (!((hi && e > 0) || (lo && e < 0))) m_int[c] = i;
`else
      m_int[c] = i;
`endif
      m_last[c] = e;
    end
    ex.d0 = m_duty[0]; ex.d1 = m_duty[1]; ex.s = m_sat[0] + 2 * m_sat[1];
    sb_q.push_back(ex);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb_q.delete();
  endtask

  // Launch one sample, follow its timing and compare against the scoreboard
  task automatic run_sample(input int sp0, input int fb0, input int sp1, input int fb1,
                            input bit pulse_mid, input string tag);
    longint prev0, prev1;
    int     k;
    int     qs;
    exp_t   ex;
    prev0 = m_duty[0];
    prev1 = m_duty[1];
    model_sample(sp0, fb0, sp1, fb1);
    @(negedge clk);
    setpoint  = {POS_W'(sp1), POS_W'(sp0)};
    feedback  = {POS_W'(fb1), POS_W'(fb0)};
    sample_en = 1'b1;
    @(posedge clk);  // edge T
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        sample_en = 1'b0;
        setpoint  = ~setpoint;   // snapshot must shield the update
        feedback  = ~feedback;
        check_val({tag, " busy_start"}, 64'(busy), 64'd1);
      end
      if (k == 1) begin
        if (pulse_mid) sample_en = 1'b1;
        check_val({tag, " ch0_hold"}, 64'(duty_out[0 +: DUTY_W]), prev0);
      end
      if (k == 2) begin
        sample_en = 1'b0;
        check_val({tag, " ch0_update"}, 64'(duty_out[0 +: DUTY_W]), sb_q[0].d0);
      end
      if (k == 3) check_val({tag, " ch1_hold"}, 64'(duty_out[DUTY_W +: DUTY_W]), prev1);
      if (k == 4) check_val({tag, " ch1_update"}, 64'(duty_out[DUTY_W +: DUTY_W]), sb_q[0].d1);
      if (duty_valid) break;
    end
    check_val({tag, " valid_cycle"}, 64'(k), 64'(2 * NCH + 1));
    qs = sb_q.size();
    check_val({tag, " sb_depth"}, 64'(qs), 64'd1);
    if (qs > 0) begin
      ex = sb_q.pop_front();
      check_val({tag, " duty0"}, 64'(duty_out[0 +: DUTY_W]), ex.d0);
      check_val({tag, " duty1"}, 64'(duty_out[DUTY_W +: DUTY_W]), ex.d1);
      check_val({tag, " sat"}, 64'(sat), ex.s);
    end
    check_val({tag, " busy_end"}, 64'(busy), 64'd0);
    @(negedge clk);
    check_val({tag, " valid_single"}, 64'(duty_valid), 64'd0);
  endtask

  task automatic watch_no_valid(input int cycles, input string tag);
    int pulses;
    pulses = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (duty_valid) pulses++;
    end
    check_val({tag, " no_valid"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sample_en = 1'b0;
    setpoint = '0;
    feedback = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check_val("rst duty0", 64'(duty_out[0 +: DUTY_W]), 64'd75000);
    check_val("rst duty1", 64'(duty_out[DUTY_W +: DUTY_W]), 64'd75000);
    check_val("rst sat", 64'(sat), 64'd0);
    check_val("rst busy", 64'(busy), 64'd0);
    watch_no_valid(10, "rst");

    // Zero error on both channels
    run_sample(2048, 2048, 2048, 2048, 1'b0, "zero");
    check_val("zero duty0_const", 64'(duty_out[0 +: DUTY_W]), 64'd75000);
    check_val("zero duty1_const", 64'(duty_out[DUTY_W +: DUTY_W]), 64'd75000);

    // Small error on ch0: P + I + D, then P + I with d = 0
    do_reset();
    run_sample(2100, 2048, 2048, 2048, 1'b0, "e52_a");
    check_val("e52_a duty0_const", 64'(duty_out[0 +: DUTY_W]), 64'd80772);
    check_val("e52_a duty1_const", 64'(duty_out[DUTY_W +: DUTY_W]), 64'd75000);
    run_sample(2100, 2048, 2048, 2048, 1'b0, "e52_b");
    check_val("e52_b duty0_const", 64'(duty_out[0 +: DUTY_W]), 64'd80304);

    // Saturation high, low, then return to zero error
    do_reset();
    run_sample(3048, 2048, 2048, 2048, 1'b0, "sat_hi");
    check_val("sat_hi duty0_const", 64'(duty_out[0 +: DUTY_W]), 64'd100000);
    check_val("sat_hi sat_const", 64'(sat), 64'd1);
    run_sample(1048, 2048, 2048, 2048, 1'b0, "sat_lo");
    check_val("sat_lo duty0_const", 64'(duty_out[0 +: DUTY_W]), 64'd50000);
    check_val("sat_lo sat_const", 64'(sat), 64'd1);
    run_sample(2048, 2048, 2048, 2048, 1'b0, "sat_zero");
`ifndef PID_ANTIWINDUP_EN
    check_val("sat_zero duty0_const", 64'(duty_out[0 +: DUTY_W]), 64'd85000);
`endif
    check_val("sat_zero sat_const", 64'(sat), 64'd0);

    // sample_en during busy is ignored: one duty_valid only
    do_reset();
    run_sample(2100, 2048, 2000, 2048, 1'b1, "ignore");
    watch_no_valid(8, "ignore");
    check_val("ignore busy_idle", 64'(busy), 64'd0);

    // Reset mid-update aborts with no duty_valid
    do_reset();
    @(negedge clk);
    setpoint  = {POS_W'(2048), POS_W'(3048)};
    feedback  = {POS_W'(2048), POS_W'(2048)};
    sample_en = 1'b1;
    @(posedge clk);  // edge T
    @(negedge clk);
    sample_en = 1'b0;
    @(posedge clk);  // T+1
    @(posedge clk);  // T+2: ch0 written
    @(negedge clk);
    check_val("abort ch0_before", 64'(duty_out[0 +: DUTY_W]), 64'd100000);
    rst_n = 1'b0;
    #1;
    check_val("abort duty0", 64'(duty_out[0 +: DUTY_W]), 64'd75000);
    check_val("abort duty1", 64'(duty_out[DUTY_W +: DUTY_W]), 64'd75000);
    check_val("abort sat", 64'(sat), 64'd0);
    check_val("abort busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    watch_no_valid(10, "abort");

    // Integral clamp: sustained +1000 error on ch0, small negative on ch1
    do_reset();
    for (int n = 0; n < 70; n++) run_sample(3048, 2048, 2045, 2048, 1'b0, "wind");
    run_sample(1548, 2048, 2045, 2048, 1'b0, "unwind");
`ifndef PID_ANTIWINDUP_EN
    check_val("unwind duty0_const", 64'(duty_out[0 +: DUTY_W]), 64'd75035);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
